// File: rtl/pc_predict_unit.sv
// pc_predict_unit
//   Fetch program counter with a direct-mapped branch target buffer (BTB).
//   The current fetch PC is looked up combinationally; a hit whose 2-bit
//   saturating counter is in a taken state (ctr[1]=1) predicts the stored
//   target, otherwise PC+4. EX-stage redirects override everything, stalls
//   hold the PC, and ihit lets the PC advance to the predicted next PC.
//   Resolved branch outcomes (upd_*) train the BTB at the clock edge.
//
// Ports
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   ihit         instruction fetched this cycle; PC may advance
//   stall        hold PC (lower priority than redirect)
//   redirect     EX-stage correction valid
//   redirect_pc  corrected fetch PC (bits [1:0] ignored)
//   upd_en       resolved control-transfer instruction present
//   upd_pc       PC of the resolved instruction
//   upd_taken    resolved direction
//   upd_target   resolved target (bits [1:0] ignored)
//   imemaddr     current fetch PC
//   pred_taken   prediction for the instruction at imemaddr
//   pred_target  predicted next PC
module pc_predict_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned BTB_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imemaddr,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = 30 - IDX_W;

    // BTB storage; targets are kept word-aligned so only [31:2] is stored.
    logic             valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
    logic [29:0]      target_q [BTB_DEPTH];
    logic [1:0]       ctr_q    [BTB_DEPTH];

    logic [31:0] pc_q, pc_d;

    // Lookup on the current PC; sees pre-update contents by construction.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [31:0]      pc_plus4;

    // Update side.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr, ctr_inc, ctr_dec;

    always_comb begin
        lk_idx      = pc_q[IDX_W+1:2];
        lk_tag      = pc_q[31:IDX_W+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pc_plus4    = pc_q + 32'd4;  // wraps modulo 2^32
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? {target_q[lk_idx], 2'b00} : pc_plus4;
        imemaddr    = pc_q;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ihit) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= {PC_RESET[31:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        up_idx  = upd_pc[IDX_W+1:2];
        up_tag  = upd_pc[31:IDX_W+2];
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr  = ctr_q[up_idx];
        ctr_inc = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
        ctr_dec = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    ctr_q[up_idx]    <= ctr_inc;
                    target_q[up_idx] <= upd_target[31:2];
                end else begin
                    ctr_q[up_idx] <= ctr_dec;
                end
            end else if (upd_taken) begin
                // Miss + taken: overwrite whatever occupies this index.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target[31:2];
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit (PC_RESET=0, BTB_DEPTH=8). A small reference
// model predicts the next PC for each driven cycle; that expectation is
// queued at drive time and popped after the clock edge.
module tb_pc_predict_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, redirect, upd_en, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] imemaddr, pred_target;
    logic        pred_taken;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic        m_valid [8];
    logic [26:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    logic [1:0]  m_ctr   [8];
    logic [31:0] m_pc;
    logic [31:0] exp_q [$];

    pc_predict_unit #(
        .PC_RESET  (32'h0000_0000),
        .BTB_DEPTH (8)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .imemaddr    (imemaddr),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 2'b01;
        end
    endtask

    task automatic idle_inputs();
        ihit = 0; stall = 0; redirect = 0; redirect_pc = 0;
        upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    endtask

    // Called just after a rising edge: drive one cycle, check the lookup,
    // take the edge, then check the PC that results.
    task automatic step(input logic ih, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic ue,
                        input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg);
        int          i, j;
        logic        hit, pt, uh;
        logic [31:0] ptg, nxt;
        ihit = ih; stall = st; redirect = rd; redirect_pc = rpc;
        upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utg;
        i   = int'(m_pc[4:2]);
        hit = m_valid[i] && (m_tag[i] == m_pc[31:5]);
        pt  = hit && m_ctr[i][1];
        ptg = pt ? m_tgt[i] : m_pc + 32'd4;
        if (rd)      nxt = {rpc[31:2], 2'b00};
        else if (st) nxt = m_pc;
        else if (ih) nxt = ptg;
        else         nxt = m_pc;
        exp_q.push_back(nxt);
        #1;
        check("lookup_addr", imemaddr, m_pc);
        check("lookup_taken", {31'b0, pred_taken}, {31'b0, pt});
        check("lookup_target", pred_target, ptg);
        @(posedge CLK);
        m_pc = nxt;
        if (ue) begin
            j  = int'(upc[4:2]);
            uh = m_valid[j] && (m_tag[j] == upc[31:5]);
            if (uh && ut) begin
                if (m_ctr[j] != 2'b11) m_ctr[j] = m_ctr[j] + 2'd1;
                m_tgt[j] = {utg[31:2], 2'b00};
            end else if (uh) begin
                if (m_ctr[j] != 2'b00) m_ctr[j] = m_ctr[j] - 2'd1;
            end else if (ut) begin
                m_valid[j] = 1'b1;
                m_tag[j]   = upc[31:5];
                m_tgt[j]   = {utg[31:2], 2'b00};
                m_ctr[j]   = 2'b10;
            end
        end
        #1;
        idle_inputs();
        if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
        else check("next_pc", imemaddr, exp_q.pop_front());
    endtask

    task automatic fetch();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] a);
        step(0, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(0, 0, 0, 0, 1, pc, t, tg);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        nRST = 1'b0;
        #3;
        check("rst_addr", imemaddr, 32'h0);
        check("rst_taken", {31'b0, pred_taken}, 32'h0);
        check("rst_target", pred_target, 32'h4);
        #9 nRST = 1'b1;  // released at t=12, between edges

        // Sequential fetch 0,4,8,12,16.
        for (int k = 0; k < 4; k++) fetch();
        check("seq_pc", imemaddr, 32'h10);

        // Stall with ihit, then idle without ihit, then redirect under stall.
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("stall_hold", imemaddr, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_hold", imemaddr, 32'h10);
        step(1, 1, 1, 32'h40, 0, 0, 0, 0);
        check("redirect_over_stall", imemaddr, 32'h40);

        // Training and hysteresis.
        train(32'h20, 1, 32'h100);
        jump(32'h20);
        check("trained_taken", {31'b0, pred_taken}, 32'h1);
        check("trained_target", pred_target, 32'h100);
        fetch();
        check("follow_pred", imemaddr, 32'h100);
        train(32'h20, 0, 32'h0);
        jump(32'h20);
        check("hyst_nt", {31'b0, pred_taken}, 32'h0);
        check("hyst_nt_tgt", pred_target, 32'h24);
        train(32'h20, 1, 32'h100);
        jump(32'h20);
        check("hyst_retaken", pred_target, 32'h100);

        // Aliasing: 0x40 shares index 0 with 0x20.
        train(32'h40, 1, 32'h200);
        jump(32'h20);
        check("alias_miss", pred_target, 32'h24);
        jump(32'h40);
        check("alias_hit", pred_target, 32'h200);
        train(32'h60, 0, 32'h500);
        jump(32'h60);
        check("nt_no_alloc", pred_target, 32'h64);
        jump(32'h40);
        check("alias_kept", pred_target, 32'h200);

        // Update and lookup at the same index in the same cycle.
        jump(32'h20);
        step(1, 0, 0, 0, 1, 32'h20, 1, 32'h303);
        check("rdw_old", imemaddr, 32'h24);
        jump(32'h23);
        check("redir_align", imemaddr, 32'h20);
        check("rdw_new", pred_target, 32'h300);

        // Wrap-around.
        jump(32'hFFFF_FFFC);
        check("wrap_target", pred_target, 32'h0);
        fetch();
        check("wrap_pc", imemaddr, 32'h0);

        // Reset mid-cycle with a pending update that must be discarded.
        jump(32'h20);
        upd_en = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h700;
        ihit = 1;
        #2 nRST = 1'b0;
        #1;
        check("midrst_addr", imemaddr, 32'h0);
        check("midrst_taken", {31'b0, pred_taken}, 32'h0);
        model_reset();
        @(posedge CLK);
        #3;
        idle_inputs();
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_pc", imemaddr, 32'h0);
        jump(32'h20);
        check("post_rst_20", {31'b0, pred_taken}, 32'h0);
        jump(32'h40);
        check("post_rst_40", pred_target, 32'h44);
        fetch();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Next-generation fetch program counter for the pipelined core.
- Holds the fetch PC, drives the instruction-memory address and predicts the next PC from a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Accepts a stall, and a redirect from the EX stage that corrects a mispredict.
- Receives resolved branch/jump outcomes to train the BTB.

Parameters:
- PC_RESET, 32'h0000_0000, fetch PC loaded on reset.
- BTB_DEPTH, 8, number of BTB entries; power of 2, >= 2. IDX_W = clog2(BTB_DEPTH), TAG_W = 30 - IDX_W.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetched this cycle; PC may advance.
- stall  in  1  hazard stall; hold PC even when ihit=1.
- redirect  in  1  EX-stage correction valid.
- redirect_pc  in  32  corrected fetch PC.
- upd_en  in  1  resolved control-transfer instruction present in EX.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target address.
- imemaddr  out  32  current fetch PC.
- pred_taken  out  1  prediction for the instruction at imemaddr.
- pred_target  out  32  predicted next PC, carried down the pipeline for the EX compare.

Behaviour:
- Clocking and reset: CLK is the only clock. nRST is asynchronous and active-low.
- Reset values:
  - PC = PC_RESET.
  - Every BTB entry: valid=0, tag=0, target=0, ctr=2'b01.
  - Outputs: imemaddr=PC_RESET, pred_taken=0, pred_target=PC_RESET+4.
  - Reset asserted mid-operation clears the BTB fully and discards any pending update.
- Alignment:
  - PC[1:0] is always 00.
  - redirect_pc[1:0] and upd_target[1:0] are ignored (forced to 00).
- Index and tag fields: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
- Lookup (combinational, current PC):
  - hit = valid[idx] && tag[idx]==PC tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : PC+4.
  - PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Next-PC priority at each rising edge:
  1. redirect=1 -> PC <= redirect_pc, regardless of ihit or stall.
  2. stall=1 -> hold.
  3. ihit=1 -> PC <= pred_target.
  4. Otherwise hold.
- BTB update on upd_en=1 at the edge, using upd_pc for index and tag:
  - Entry hit, taken: ctr saturating increment (max 2'b11); target <= upd_target.
  - Entry hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate (overwrite) with valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not taken: no change.
- Update and redirect are independent; both may occur in the same cycle.
- Read-during-write: a lookup in the same cycle as an update to the same index sees the pre-update contents. The new contents are visible from the next cycle.
- Latency: pred_taken and pred_target change in the same cycle as PC (zero-cycle lookup). The first predicted-taken fetch occurs on the fetch following training.

Test Plan:
- Reset:
  - Stimulus: PC_RESET=32'h0000_0000; hold nRST low, release; ihit=1 for 3 cycles, no updates.
  - Required response: imemaddr = 0, 4, 8, 12; pred_taken=0 throughout.
- Stall and hold:
  - Stimulus: at PC=0x10, stall=1 with ihit=1 for 2 cycles.
  - Required response: PC stays 0x10. Same for ihit=0 with stall=0.
  - Stimulus: then redirect=1, redirect_pc=0x40 with stall=1.
  - Required response: PC=0x40 next cycle.
- Training and hysteresis (BTB_DEPTH=8):
  - Stimulus: upd_en with upd_pc=0x20, taken, target 0x100; then fetch 0x20.
  - Required response: pred_taken=1, pred_target=0x100; next PC=0x100 on ihit.
  - Stimulus: one not-taken update for 0x20.
  - Required response: ctr=01, pred_taken=0 with entry still valid. One more taken update gives ctr=10 and prediction taken again.
- Aliasing:
  - Stimulus: train 0x20 taken, then train 0x40 taken with target 0x200 (same index, different tag). Fetch 0x20.
  - Required response: miss, pred_target=0x24. Fetch 0x40 gives pred_target=0x200.
  - Stimulus: a not-taken update for an untrained 0x60.
  - Required response: no allocation.
- Simultaneous update and lookup:
  - Stimulus: PC=0x20 with ihit=1 while upd_en trains 0x20 taken in the same cycle.
  - Required response: that cycle uses PC+4 (0x24).
- Wrap-around:
  - Stimulus: redirect to 32'hFFFF_FFFC, then ihit.
  - Required response: PC=0.
- Reset mid-operation:
  - Stimulus: after training, assert nRST mid-cycle.
  - Required response: imemaddr=PC_RESET immediately; all predictions not-taken afterwards.
